// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtractor controller.
// Feeds the 1-bit full-subtractor cell sub1 one operand bit per clock, LSB
// first, then publishes the difference, borrow-out and status flags together
// with a one-cycle done pulse.
// Optional feature macro: SERIAL_SUB_CMP_EN adds registered eq/lt_u/lt_s.

// 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module sub1 (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    // Pure combinational difference and borrow.
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & (y | bi)) | (y & bi);
    end
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
`ifdef SERIAL_SUB_CMP_EN
    output logic             eq,
    output logic             lt_u,
    output logic             lt_s,
`endif
    output logic             ovf
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic             brw;
    logic [CW-1:0]    cnt;
`ifdef SERIAL_SUB_CMP_EN
    logic             bin_cap;
`endif

    logic             cell_d;
    logic             cell_b;
    logic [WIDTH-1:0] diff_nxt;

    sub1 u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (brw),
        .d  (cell_d),
        .bo (cell_b)
    );

    // Result register after this cycle's shift: new diff bit enters at the MSB.
    always_comb begin
        diff_nxt = {cell_d, diff_sh[WIDTH-1:1]};
    end

    // Control FSM with datapath shift registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            brw     <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
`ifdef SERIAL_SUB_CMP_EN
            bin_cap <= 1'b0;
            eq      <= 1'b0;
            lt_u    <= 1'b0;
            lt_s    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef SERIAL_SUB_CMP_EN
                        bin_cap <= bin;
`endif
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= diff_nxt;
                    brw     <= cell_b;
                    if (cnt == LAST) begin
                        // Last bit: brw is the borrow into the MSB, so signed
                        // overflow is the carry-in/carry-out disagreement.
                        state <= DONE;
                        done  <= 1'b1;
                        diff  <= diff_nxt;
                        bout  <= cell_b;
                        zero  <= (diff_nxt == '0);
                        neg   <= cell_d;
                        ovf   <= brw ^ cell_b;
`ifdef SERIAL_SUB_CMP_EN
                        eq    <= (diff_nxt == '0) && !bin_cap;
                        lt_u  <= cell_b && !bin_cap;
                        lt_s  <= cell_d ^ (brw ^ cell_b);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: randomized and directed checks of serial_sub_ctrl
// against an arithmetic reference model. Define SERIAL_SUB_CMP_EN to also
// check the comparison outputs.
module tb_serial_sub_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout, zero, neg, ovf;
    logic [W-1:0] diff;
    logic         eq, lt_u, lt_s;

    int vectors = 0;
    int miscompares = 0;

    // Expected held outputs (model state)
    logic [W-1:0] m_diff = '0;
    logic         m_bout = 1'b0, m_zero = 1'b0, m_neg = 1'b0, m_ovf = 1'b0;
    logic         m_eq = 1'b0, m_ltu = 1'b0, m_lts = 1'b0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero),
        .neg   (neg),
`ifdef SERIAL_SUB_CMP_EN
        .eq    (eq),
        .lt_u  (lt_u),
        .lt_s  (lt_s),
`endif
        .ovf   (ovf)
    );

`ifndef SERIAL_SUB_CMP_EN
    assign eq = 1'b0;
    assign lt_u = 1'b0;
    assign lt_s = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(ta);
        ub = int'(tb_v);
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        ur = ua - ub - int'(tbin);
        sr = sa - sb - int'(tbin);
        m_diff = W'(ur & ((1 << W) - 1));
        m_bout = (ur < 0);
        m_zero = (m_diff == 0);
        m_neg  = m_diff[W-1];
        m_ovf  = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
        m_eq   = (ua == ub) && !tbin;
        m_ltu  = (ua < ub) && !tbin;
        m_lts  = (sr < 0);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".diff"}, 32'(diff), 32'(m_diff));
        check({tag, ".bout"}, 32'(bout), 32'(m_bout));
        check({tag, ".zero"}, 32'(zero), 32'(m_zero));
        check({tag, ".neg"},  32'(neg),  32'(m_neg));
        check({tag, ".ovf"},  32'(ovf),  32'(m_ovf));
`ifdef SERIAL_SUB_CMP_EN
        check({tag, ".eq"},   32'(eq),   32'(m_eq));
        check({tag, ".lt_u"}, 32'(lt_u), 32'(m_ltu));
        check({tag, ".lt_s"}, 32'(lt_s), 32'(m_lts));
`endif
    endtask

    // One full operation; poke=1 hammers start with other operands while busy.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tbin, input bit poke, input string tag);
        int lat;
        int extra;
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (poke) begin
            a = 8'h7F; b = 8'h80; bin = 1'b0;
        end else begin
            start = 1'b0;
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        end
        check({tag, ".busy_run"}, 32'(busy), 32'd1);
        check({tag, ".done_early"}, 32'(done), 32'd0);
        lat = 0;
        while (!done && lat < W + 4) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        model(ta, tb_v, tbin);
        check({tag, ".latency"}, 32'(lat), 32'(W));
        check({tag, ".busy_done"}, 32'(busy), 32'd1);
        check_outputs(tag);
        $display("op %s a=%h b=%h bin=%b -> diff=%h bout=%b zero=%b neg=%b ovf=%b lat=%0d",
                 tag, ta, tb_v, tbin, diff, bout, zero, neg, ovf, lat);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".busy_end"}, 32'(busy), 32'd0);
        if (poke) begin
            extra = 0;
            for (int i = 0; i < W + 4; i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check({tag, ".no_extra_done"}, 32'(extra), 32'd0);
            check({tag, ".busy_idle"}, 32'(busy), 32'd0);
            check_outputs({tag, ".hold"});
        end
    endtask

    initial begin
        // Reset state while held and after release
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel.busy", 32'(busy), 32'd0);

        // Directed vectors
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, "d5a_3c");
        run_op(8'h00, 8'h01, 1'b0, 1'b0, "d00_01");
        run_op(8'h80, 8'h01, 1'b0, 1'b0, "d80_01");
        run_op(8'h10, 8'h0F, 1'b1, 1'b1, "d10_0f_busy");
        run_op(8'h7F, 8'h80, 1'b0, 1'b0, "d7f_80");
        run_op(8'h42, 8'h42, 1'b0, 1'b0, "d42_42");

        // Reset mid-operation
        @(negedge clk);
        a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_diff = '0; m_bout = 0; m_zero = 0; m_neg = 0; m_ovf = 0;
        m_eq = 0; m_ltu = 0; m_lts = 0;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check_outputs("midrst");
        $display("op midrst a=ff b=01 aborted after 4 RUN cycles");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h03, 8'h05, 1'b0, 1'b0, "d03_05");

        // Random vectors, occasionally with start hammered while busy
        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
